// File: rtl/dsp_seq_pkg.sv
// Shared constants and state encoding for the DSP slice MAC sequencer.
package dsp_seq_pkg;

    // Slice control strings; the slice computes P = C + 2*A*B in MAC mode
    // and P = C in hold mode.
    localparam logic [6:0] OPMODE_MAC  = 7'h35;
    localparam logic [6:0] OPMODE_HOLD = 7'h30;
    localparam logic [3:0] ALUMODE_ADD = 4'b0000;
    localparam logic [4:0] INMODE_A    = 5'b00001;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        RESP
    } state_t;

endpackage

// File: rtl/dsp_mac_sequencer.sv
// Initiator-side controller for one DSP48E-style slice: streams a job of
// LEN operand pairs into the slice one term per cycle and returns
// bias + sum(a*b) mod 2^47. The slice runs at 2x scale (P = C + 2AB),
// so the bias is presented doubled and the result is P[47:1].
module dsp_mac_sequencer #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [46:0]      cmd_bias,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [24:0]      op_a,
    input  logic [17:0]      op_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [46:0]      res_data,
    output logic [29:0]      dsp_a,
    output logic [17:0]      dsp_b,
    output logic [47:0]      dsp_c,
    output logic [24:0]      dsp_d,
    output logic             dsp_carryin,
    output logic [3:0]       dsp_alumode,
    output logic [6:0]       dsp_opmode,
    output logic [4:0]       dsp_inmode,
    input  logic [47:0]      dsp_p
);
    import dsp_seq_pkg::*;

    state_t           state;
    logic [LEN_W-1:0] cnt;
    logic [46:0]      bias_q;
    logic             issue_first;
    logic             cmd_fire;
    logic             op_fire;
    logic             first_clear;
    logic             p_lsb_unused;

    assign cmd_ready = (state == IDLE);
    assign op_ready  = (state == ACCUM);
    assign res_valid = (state == RESP);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign op_fire   = op_valid && op_ready;

    // P is always even at 2x scale; the LSB carries no information.
    assign res_data     = dsp_p[47:1];
    assign p_lsb_unused = dsp_p[0];

    // While armed (hold opmode) the flag stays set so repeated bubbles keep
    // reloading the bias; once the first term has been issued (MAC opmode)
    // it drops and the accumulation feeds back through P.
    assign first_clear = issue_first && (dsp_opmode == OPMODE_HOLD);

    // C selects the doubled bias for the first term, otherwise recirculates P
    // so that hold opmode freezes the accumulator.
    assign dsp_c = issue_first ? {bias_q, 1'b0} : dsp_p;

    assign dsp_d       = '0;
    assign dsp_carryin = 1'b0;
    assign dsp_alumode = ALUMODE_ADD;
    assign dsp_inmode  = INMODE_A;

    // Job sequencing and registered slice inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            bias_q      <= '0;
            issue_first <= 1'b0;
            dsp_a       <= '0;
            dsp_b       <= '0;
            dsp_opmode  <= OPMODE_HOLD;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_fire) begin
                        bias_q      <= cmd_bias;
                        cnt         <= cmd_len;
                        dsp_opmode  <= OPMODE_HOLD;
                        issue_first <= 1'b1;
                        state       <= (cmd_len == '0) ? DRAIN : ACCUM;
                    end
                end
                ACCUM: begin
                    issue_first <= first_clear;
                    if (op_fire) begin
                        dsp_a      <= {5'b0, op_a};
                        dsp_b      <= op_b;
                        dsp_opmode <= OPMODE_MAC;
                        cnt        <= cnt - LEN_W'(1);
                        if (cnt == LEN_W'(1)) begin
                            state <= DRAIN;
                        end
                    end else begin
                        dsp_opmode <= OPMODE_HOLD;
                    end
                end
                DRAIN: begin
                    dsp_opmode  <= OPMODE_HOLD;
                    issue_first <= 1'b0;
                    state       <= RESP;
                end
                RESP: begin
                    if (res_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Self-checking bench: sequencer plus a behavioural DSP slice, checked each
// cycle against a job-level model (bias + sum of products, handshake counts,
// result due two cycles after the last accepted transfer).
module tb_dsp_mac_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_len;
    logic [46:0] cmd_bias;
    logic        op_valid;
    logic        op_ready;
    logic [24:0] op_a;
    logic [17:0] op_b;
    logic        res_valid;
    logic        res_ready;
    logic [46:0] res_data;
    logic [29:0] dsp_a;
    logic [17:0] dsp_b;
    logic [47:0] dsp_c;
    logic [24:0] dsp_d;
    logic        dsp_carryin;
    logic [3:0]  dsp_alumode;
    logic [6:0]  dsp_opmode;
    logic [4:0]  dsp_inmode;
    logic [47:0] dsp_p = '0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dsp_mac_sequencer #(.LEN_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len), .cmd_bias(cmd_bias),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_c(dsp_c), .dsp_d(dsp_d),
        .dsp_carryin(dsp_carryin), .dsp_alumode(dsp_alumode), .dsp_opmode(dsp_opmode),
        .dsp_inmode(dsp_inmode), .dsp_p(dsp_p)
    );

    // Behavioural slice: P = C + 2*A*B (MAC) or P = C (hold), one-cycle latency.
    always @(posedge clk) begin
        if (dsp_opmode == 7'h35)
            dsp_p <= dsp_c + 48'(2) * 48'(dsp_a[24:0]) * 48'(dsp_b);
        else if (dsp_opmode == 7'h30)
            dsp_p <= dsp_c;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- job-level reference model ----------------
    logic        busy;
    int          terms_left;
    int          cyc = 0;
    int          ready_cyc;
    logic [46:0] exp_acc;
    logic        prev_op;
    logic [24:0] last_a;
    logic [17:0] last_b;
    logic        exp_rv;

    assign exp_rv = busy && (terms_left == 0) && (cyc >= ready_cyc);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= 1'b0;
            terms_left <= 0;
            ready_cyc  <= 0;
            exp_acc    <= '0;
            prev_op    <= 1'b0;
        end else begin
            cyc     <= cyc + 1;
            prev_op <= 1'b0;
            if (!busy && cmd_valid) begin
                busy       <= 1'b1;
                terms_left <= int'(cmd_len);
                exp_acc    <= cmd_bias;
                if (cmd_len == 8'd0) ready_cyc <= cyc + 2;
            end else if (busy && terms_left > 0 && op_valid) begin
                exp_acc    <= exp_acc + 47'(op_a) * 47'(op_b);
                terms_left <= terms_left - 1;
                prev_op    <= 1'b1;
                last_a     <= op_a;
                last_b     <= op_b;
                if (terms_left == 1) ready_cyc <= cyc + 2;
            end else if (exp_rv && res_ready) begin
                busy <= 1'b0;
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("cmd_ready", cmd_ready, !busy);
            chk("op_ready", op_ready, busy && terms_left > 0);
            chk("res_valid", res_valid, exp_rv);
            if (exp_rv) chk("res_data", res_data, exp_acc);
            chk("opmode", dsp_opmode, prev_op ? 7'h35 : 7'h30);
            if (prev_op) chk("dsp_ab", {dsp_a, dsp_b}, {5'b0, last_a, last_b});
            chk("consts", {dsp_d, dsp_carryin, dsp_alumode, dsp_inmode}, {25'd0, 1'b0, 4'd0, 5'd1});
        end
    end

    // ---------------- stimulus ----------------
    logic [24:0] ta [0:255];
    logic [17:0] tb_b [0:255];

    // gap < 0 selects a random 0..2 cycle gap before each term.
    task automatic run_job(input logic [46:0] bias, input int len, input int gap,
                           input int stall, input bit use_lit, input logic [46:0] lit);
        int w = 0;
        while (!cmd_ready && w < 200) begin @(negedge clk); w++; end
        if (w >= 200) begin chk("cmd_wait_timeout", 0, 1); return; end
        cmd_valid = 1'b1;
        cmd_len   = 8'(len);
        cmd_bias  = bias;
        op_valid  = 1'($urandom);
        op_a      = 25'($urandom);
        @(negedge clk);
        cmd_valid = 1'b0;
        op_valid  = 1'b0;
        for (int i = 0; i < len; i++) begin
            int g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            op_valid = 1'b0;
            for (int k = 0; k < g; k++) begin
                @(negedge clk);
                chk("gap_opmode", dsp_opmode, 7'h30);
            end
            w = 0;
            while (!op_ready && w < 200) begin @(negedge clk); w++; end
            if (w >= 200) begin chk("op_wait_timeout", 0, 1); return; end
            op_valid = 1'b1;
            op_a     = ta[i];
            op_b     = tb_b[i];
            @(negedge clk);
        end
        op_valid = 1'b0;
        chk("lat_drain", res_valid, 0);
        @(negedge clk);
        chk("lat_resp", res_valid, 1);
        for (int s = 0; s < stall; s++) begin
            if (use_lit) chk("stall_data", res_data, lit);
            chk("stall_cmd_ready", cmd_ready, 0);
            chk("stall_op_ready", op_ready, 0);
            op_valid = 1'($urandom);
            op_a     = 25'($urandom);
            @(negedge clk);
        end
        if (use_lit) chk("res_lit", res_data, lit);
        op_valid  = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; cmd_valid = 0; cmd_len = 0; cmd_bias = 0;
        op_valid = 0; op_a = 0; op_b = 0; res_ready = 0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_op_ready", op_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_opmode", dsp_opmode, 7'h30);
        chk("rst_dsp_ab", {dsp_a, dsp_b}, 48'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk);

        // 10 + 2*3 + 4*5 + 6*7 = 78, back-to-back then with 2-cycle gaps
        ta[0] = 2; tb_b[0] = 3; ta[1] = 4; tb_b[1] = 5; ta[2] = 6; tb_b[2] = 7;
        run_job(47'd10, 3, 0, 0, 1'b1, 47'd78);
        run_job(47'd10, 3, 2, 0, 1'b1, 47'd78);

        // empty job, result held through a 5-cycle stall
        run_job(47'd123, 0, 0, 5, 1'b1, 47'd123);

        // full-scale operands: 2*(2^25-1)*(2^18-1)
        ta[0] = 25'h1FFFFFF; tb_b[0] = 18'h3FFFF; ta[1] = 25'h1FFFFFF; tb_b[1] = 18'h3FFFF;
        run_job(47'd0, 2, 0, 0, 1'b1, 47'd17592118411266);

        // wrap modulo 2^47
        ta[0] = 1; tb_b[0] = 1;
        run_job(47'h7FFF_FFFF_FFFF, 1, 0, 0, 1'b1, 47'd0);

        // reset in the middle of an accumulation
        while (!cmd_ready) @(negedge clk);
        cmd_valid = 1; cmd_len = 3; cmd_bias = 47'd55;
        @(negedge clk);
        cmd_valid = 0; op_valid = 1; op_a = 9; op_b = 9;
        @(negedge clk);
        op_valid = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_cmd_ready", cmd_ready, 1);
        chk("mid_rst_op_ready", op_ready, 0);
        chk("mid_rst_res_valid", res_valid, 0);
        chk("mid_rst_opmode", dsp_opmode, 7'h30);
        chk("mid_rst_dsp_ab", {dsp_a, dsp_b}, 48'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk);
        ta[0] = 3; tb_b[0] = 4;
        run_job(47'd1, 1, 0, 0, 1'b1, 47'd13);

        // randomized jobs checked by the model
        for (int j = 0; j < 40; j++) begin
            int len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(7, 20))
                                                  : int'($urandom_range(0, 6));
            logic [46:0] bias = 47'({$urandom, $urandom});
            for (int i = 0; i < len; i++) begin
                ta[i]   = ($urandom_range(0, 7) == 0) ? 25'h1FFFFFF : 25'($urandom);
                tb_b[i] = ($urandom_range(0, 7) == 0) ? 18'h3FFFF   : 18'($urandom);
            end
            run_job(bias, len, -1, int'($urandom_range(0, 3)), 1'b0, 47'd0);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dsp_mac_sequencer.md
Name: dsp_mac_sequencer

Overview:
Initiator-side controller for the team's DSP48E-style slice. It accepts a multiply-accumulate job: a bias plus LEN operand pairs streamed over valid/ready. It drives the slice's operand and control-string inputs one term per cycle and reads back the slice's registered P. It returns bias + Σ(a·b) on a result handshake. It sits between a CGRA tile's load path and one DSP slice instance, which is instantiated alongside it rather than inside it.

Parameters:
LEN_W, 8, width of cmd_len; a job has at most 2^LEN_W-1 terms.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  job request
cmd_ready  out  1  job accepted when both cmd_valid and cmd_ready are high
cmd_len  in  LEN_W  number of operand pairs (0 allowed)
cmd_bias  in  47  unsigned starting value
op_valid  in  1  operand pair valid
op_ready  out  1  operand pair accepted when both op_valid and op_ready are high
op_a  in  25  unsigned multiplicand
op_b  in  18  unsigned multiplier
res_valid  out  1  result valid
res_ready  in  1  result consumed when both res_valid and res_ready are high
res_data  out  47  unsigned result, modulo 2^47
dsp_a  out  30  slice A; {5'b0, op_a}, registered
dsp_b  out  18  slice B, registered
dsp_c  out  48  slice C, combinational mux
dsp_d  out  25  slice D, constant 0
dsp_carryin  out  1  constant 0
dsp_alumode  out  4  constant 4'b0000 (Z+X+Y+CIN)
dsp_opmode  out  7  registered control string
dsp_inmode  out  5  constant 5'b00001 (pre-adder passes A)
dsp_p  in  48  slice P; registered in the slice with one-cycle latency

Behaviour:
- Slice contract (decided):
  - OPMODE 7'h35 (X=M, Y=M, Z=C) yields P = C + 2·A·B.
  - OPMODE 7'h30 (X=0, Y=0, Z=C) yields P = C.
  - The sequencer therefore works at 2× scale: it presents bias as {cmd_bias,1'b0}, and res_data = dsp_p[47:1]. P is always even.
- dsp_c mux: if issue_first (a registered flag set alongside the issued dsp regs), dsp_c = {bias_q,1'b0}; otherwise dsp_c = dsp_p. With opmode 7'h30 and dsp_c = dsp_p, the slice holds P. This is the bubble/hold mode.
- Reset, asynchronous:
  - state IDLE; cmd_ready=1; op_ready=0; res_valid=0.
  - dsp_a, dsp_b = 0; dsp_opmode = 7'h30; issue_first = 0; counter = 0; bias_q = 0.
  - Reset mid-job abandons the job with no residual effect on the next one.
- States:
  - IDLE: cmd_ready=1.
    - On cmd handshake: latch bias_q and cnt=cmd_len.
    - If cmd_len==0: load dsp_opmode=7'h30, issue_first=1, go to DRAIN.
    - Otherwise: dsp_opmode=7'h30, issue_first=1 (armed, not yet issued), go to ACCUM.
  - ACCUM: op_ready=1.
    - On op handshake: dsp_a/dsp_b<=op, dsp_opmode<=7'h35, cnt<=cnt-1. issue_first<=1 only for the first term of the job; 0 thereafter. If cnt==1, go to DRAIN.
    - With no handshake (bubble): dsp_opmode<=7'h30. issue_first keeps its value until the first term issues; it is 0 after that. P holds.
  - DRAIN (1 cycle): op_ready=0. The slice computes the last issued term. Next edge: dsp_opmode<=7'h30, issue_first<=0, go to RESP.
  - RESP: res_valid=1; res_data=dsp_p[47:1], stable while res_valid is high (hold mode). On res handshake, go to IDLE.
- Timing:
  - Throughput: one term per cycle, back-to-back.
  - Term k+1 issued in the cycle after term k sees term k's P on dsp_p via dsp_c.
  - Latency: res_valid rises 2 cycles after the last op handshake edge, or 2 cycles after the cmd handshake edge when len=0.
- Boundaries:
  - cmd_ready is high only in IDLE; no command overlaps RESP.
  - Arithmetic wraps modulo 2^47 with no overflow flag.
  - op_valid outside ACCUM is ignored (op_ready=0).

Decomposition:
- Package dsp_seq_pkg holds:
  - OPMODE_MAC=7'h35, OPMODE_HOLD=7'h30
  - ALUMODE_ADD=4'b0000, INMODE_A=5'b00001
  - state enum {IDLE, ACCUM, DRAIN, RESP}
- Single module; no sub-module is needed. The testbench instantiates the slice next to the sequencer.

Test Plan:
- bias=10, len=3, ops (2,3),(4,5),(6,7) back-to-back -> res_data=78; res_valid 2 cycles after 3rd op handshake.
- Same job with op_valid low for 2 cycles between each term -> res_data=78; dsp_opmode=7'h30 during gaps.
- len=0, bias=123 -> res_data=123; res_valid 2 cycles after cmd handshake.
- res_ready low for 5 cycles in RESP -> res_data stays 123 each cycle; cmd_ready=0; op_ready=0.
- bias=0, len=2, both ops (2^25-1, 2^18-1) -> res_data = 2·(2^25-1)·(2^18-1) mod 2^47.
- rst_n pulsed low mid-ACCUM after 1 of 3 terms -> outputs at reset values immediately. Next job bias=1, len=1, (3,4) -> res_data=13.
